note_highway_renderer: RTL and testbench
========================================

// Module: note_highway_renderer
// PURPOSE
//  Pixel stage that sits downstream of the VGA timing driver and replaces the flat white fill.
//  Holds the falling notes for each lane and scrolls them once per frame.
//  Accepts note spawns and player hits, and produces the registered 12-bit RGB for the current
//  h_count/v_count. Reports hit and miss events to the scoring logic.
// PARAMETERS
//  NUM_LANES  4    number of lanes (lane index width LW = $clog2(NUM_LANES))
//  SLOTS      8    note slots per lane
//  LANE_X0    160  x of the left edge of lane 0
//  LANE_W     80   lane width in pixels
//  NOTE_H     16   note height in pixels
//  SPEED      2    pixels a note falls per frame tick
//  HIT_Y      440  y of the hit line
//  HIT_WIN    16   hit window half-width; also the miss threshold offset
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous, active-high reset
//  h_count     in   10  pixel x from the VGA driver
//  v_count     in   10  pixel y from the VGA driver
//  note_valid  in   1   spawn request
//  note_lane   in   LW  lane of the spawn request
//  note_ready  out  1   spawn accepted when note_valid & note_ready
//  hit_valid   in   1   one-cycle player strum
//  hit_lane    in   LW  lane that was strummed
//  hit_pulse   out  1   one-cycle pulse: a note was hit
//  miss_pulse  out  1   one-cycle pulse: a note passed the window
//  rgb         out  12  pixel colour, 4:4:4
// BEHAVIOUR
//  Reset: all slots inactive; rgb=12'h000; hit_pulse=0; miss_pulse=0. Reset mid-frame clears
//   everything at once. Rendering resumes on the next clock after rst deasserts.
//  Slot state: {active, y[9:0]}.
//  Frame tick: one-cycle pulse on the rising edge of the registered condition (v_count==480).
//   Exactly one tick per frame.
//  note_ready = (note_lane has a free slot) & ~tick. It is combinational on note_lane.
//  Spawn: the lowest-index free slot in note_lane gets active=1, y=0.
//  Tick: every active note advances y += SPEED.
//   If the new y >= HIT_Y+HIT_WIN, the slot clears and miss_pulse=1 on the next cycle.
//   miss_pulse asserts once per tick, even when several notes miss.
//  Hit (any cycle): among active notes in hit_lane with HIT_Y-HIT_WIN <= y <= HIT_Y+HIT_WIN,
//   clear the one with the largest y and set hit_pulse=1 on the next cycle.
//   No note in the window: no pulse and no state change.
//  Simultaneous hit+tick: the hit is judged on pre-tick y. The hit note does not advance
//   and cannot produce a miss.
//  Simultaneous spawn+hit in the same lane: both apply. A spawn at y=0 is never in the window.
//  Render, 1-cycle latency: rgb(t+1) is a function of h/v_count(t) and slot state(t).
//   Priority, highest first:
//    1. outside 640x480          -> 000
//    2. note pixel               -> lane colour
//       (x inside lane i at [+4, LANE_W-4), y <= v_count < y+NOTE_H, 11-bit compare)
//    3. hit line                 -> FFF (v_count in {HIT_Y, HIT_Y+1} within any lane span)
//    4. lane divider             -> 444 (h_count == LANE_X0+i*LANE_W, including the right edge)
//    5. otherwise                -> 000
// CONFIGURATION
//  HIT_FLASH_EN defined: after a hit in lane i, the hit line inside lane i renders 0F0 for the
//   next 8 frame ticks. Uses a 3-bit counter per lane; a new hit restarts the counter.
//  HIT_FLASH_EN undefined: the hit line is always FFF and no flash counters exist.
// STRUCTURE
//  Package note_highway_pkg: lane colour table (0F0, F00, FF0, 00F), geometry constants,
//   and note_slot_t {logic active; logic [9:0] y;}.
//  Sub-module note_lane: one lane's slot array, spawn allocation, hit search, scroll/miss,
//   and a per-pixel "note here" flag. Instantiated NUM_LANES times.
//  The top level holds tick detection, lane decode, rgb mux and pulse OR-reduction.
// TESTING
//  1. Spawn lane 0 at reset+1; 5 ticks later -> y=10. Drive (h=200, v=10) -> rgb=0F0 one cycle
//     later; (h=200, v=26) -> 000.
//  2. 8 spawns into lane 1 -> note_ready=0 for note_lane=1, 1 for note_lane=2; a 9th request is
//     not accepted.
//  3. Lane 2 note at y=432, hit_valid with hit_lane=2 -> hit_pulse for 1 cycle, slot freed;
//     repeat the hit -> no pulse.
//  4. Lane 3 note at y=454, tick -> y=456, slot cleared, miss_pulse for 1 cycle.
//  5. Lane 3 note at y=454, hit and tick in the same cycle -> hit_pulse=1, miss_pulse=0.
//  6. Assert rst mid-frame with 5 notes active -> rgb=000, all lanes ready, no pulses;
//     (h=700, v=100) -> 000.

Source files
------------

// File: rtl/note_highway_pkg.sv
// Shared geometry defaults, lane colours and the note slot record for the note highway renderer.
package note_highway_pkg;
  localparam int H_ACT = 640;
  localparam int V_ACT = 480;

  typedef struct packed {
    logic       active;
    logic [9:0] y;
  } note_slot_t;

  localparam logic [3:0][11:0] LANE_COLORS = {12'h00F, 12'hFF0, 12'hF00, 12'h0F0};

  function automatic logic [11:0] lane_color(input int i);
    logic [1:0] idx;
    idx = 2'(i % 4);
    return LANE_COLORS[idx];
  endfunction
endpackage

// File: rtl/note_highway_renderer_lane.sv
// One lane: slot array, lowest-free spawn allocation, largest-y hit search, scroll/miss, note pixel flag.
module note_lane
  import note_highway_pkg::*;
#(
  parameter int IDX     = 0,
  parameter int SLOTS   = 8,
  parameter int LANE_X0 = 160,
  parameter int LANE_W  = 80,
  parameter int NOTE_H  = 16,
  parameter int SPEED   = 2,
  parameter int HIT_Y   = 440,
  parameter int HIT_WIN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       spawn,
  input  logic       hit,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  output logic       free,
  output logic       hit_now,
  output logic       miss_now,
  output logic       note_here
);
  localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [10:0] X_LO   = 11'(LANE_X0 + IDX * LANE_W + 4);
  localparam logic [10:0] X_HI   = 11'(LANE_X0 + (IDX + 1) * LANE_W - 4);
  localparam logic [10:0] WIN_LO = 11'(HIT_Y - HIT_WIN);
  localparam logic [10:0] WIN_HI = 11'(HIT_Y + HIT_WIN);
  localparam logic [10:0] SPD    = 11'(SPEED);
  localparam logic [10:0] NH     = 11'(NOTE_H);

  note_slot_t      slots [SLOTS];
  logic [SW-1:0]   spawn_idx, hit_idx;
  logic [10:0]     best_y;
  logic            found;
  logic [10:0]     h11, v11;

  assign h11 = {1'b0, h_count};
  assign v11 = {1'b0, v_count};

  always_comb begin
    free      = 1'b0;
    spawn_idx = '0;
    found     = 1'b0;
    best_y    = '0;
    hit_idx   = '0;
    miss_now  = 1'b0;
    note_here = 1'b0;
    for (int s = SLOTS - 1; s >= 0; s--) begin
      if (!slots[s].active) begin
        free      = 1'b1;
        spawn_idx = SW'(s);
      end
    end
    // strict '>' keeps the lowest index when two notes share a y
    for (int s = 0; s < SLOTS; s++) begin
      if (slots[s].active && {1'b0, slots[s].y} >= WIN_LO && {1'b0, slots[s].y} <= WIN_HI &&
          (!found || {1'b0, slots[s].y} > best_y)) begin
        found   = 1'b1;
        best_y  = {1'b0, slots[s].y};
        hit_idx = SW'(s);
      end
    end
    hit_now = hit & found;
    for (int s = 0; s < SLOTS; s++) begin
      if (tick && slots[s].active && !(hit_now && hit_idx == SW'(s)) &&
          {1'b0, slots[s].y} + SPD >= WIN_HI)
        miss_now = 1'b1;
      if (slots[s].active && v11 >= {1'b0, slots[s].y} && v11 < {1'b0, slots[s].y} + NH &&
          h11 >= X_LO && h11 < X_HI)
        note_here = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SLOTS; s++) slots[s] <= '0;
    end else begin
      for (int s = 0; s < SLOTS; s++) begin
        if (hit_now && hit_idx == SW'(s)) begin
          slots[s].active <= 1'b0;
        end else if (tick && slots[s].active) begin
          if ({1'b0, slots[s].y} + SPD >= WIN_HI) slots[s].active <= 1'b0;
          else                                   slots[s].y      <= slots[s].y + 10'(SPEED);
        end else if (spawn && !slots[s].active && spawn_idx == SW'(s)) begin
          slots[s].active <= 1'b1;
          slots[s].y      <= '0;
        end
      end
    end
  end
endmodule

// File: rtl/note_highway_renderer.sv
// Note highway pixel stage: frame tick, lane array, registered rgb and hit/miss pulses.
// Optional HIT_FLASH_EN: hit line of a lane flashes green for 8 frame ticks after a hit.
module note_highway_renderer
  import note_highway_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int SLOTS     = 8,
  parameter int LANE_X0   = 160,
  parameter int LANE_W    = 80,
  parameter int NOTE_H    = 16,
  parameter int SPEED     = 2,
  parameter int HIT_Y     = 440,
  parameter int HIT_WIN   = 16,
  localparam int LW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    h_count,
  input  logic [9:0]    v_count,
  input  logic          note_valid,
  input  logic [LW-1:0] note_lane,
  output logic          note_ready,
  input  logic          hit_valid,
  input  logic [LW-1:0] hit_lane,
  output logic          hit_pulse,
  output logic          miss_pulse,
  output logic [11:0]   rgb
);
  logic v_last_q, v_last_q2, tick;
  logic [NUM_LANES-1:0] free, hit_now, miss_now, here, spawn_l, hit_l;
  logic [11:0] rgb_d;
  logic [10:0] h11, v11;

  assign h11 = {1'b0, h_count};
  assign v11 = {1'b0, v_count};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_last_q  <= 1'b0;
      v_last_q2 <= 1'b0;
    end else begin
      v_last_q  <= (v_count == 10'(V_ACT));
      v_last_q2 <= v_last_q;
    end
  end
  assign tick       = v_last_q & ~v_last_q2;
  assign note_ready = free[note_lane] & ~tick;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign spawn_l[i] = note_valid & note_ready & (note_lane == LW'(i));
    assign hit_l[i]   = hit_valid & (hit_lane == LW'(i));
    note_lane #(
      .IDX(i), .SLOTS(SLOTS), .LANE_X0(LANE_X0), .LANE_W(LANE_W), .NOTE_H(NOTE_H),
      .SPEED(SPEED), .HIT_Y(HIT_Y), .HIT_WIN(HIT_WIN)
    ) u_lane (
      .clk(clk), .rst(rst), .tick(tick), .spawn(spawn_l[i]), .hit(hit_l[i]),
      .h_count(h_count), .v_count(v_count), .free(free[i]), .hit_now(hit_now[i]),
      .miss_now(miss_now[i]), .note_here(here[i])
    );
  end

`ifdef HIT_FLASH_EN
  logic [NUM_LANES-1:0]      flash_on;
  logic [NUM_LANES-1:0][2:0] flash_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_on  <= '0;
      flash_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (hit_now[i]) begin
          flash_on[i]  <= 1'b1;
          flash_cnt[i] <= '0;
        end else if (tick && flash_on[i]) begin
          flash_cnt[i] <= flash_cnt[i] + 3'd1;
          if (flash_cnt[i] == 3'd7) flash_on[i] <= 1'b0;
        end
      end
    end
  end
`endif

  always_comb begin
    logic        any_note, in_span, hit_row, divider;
    logic [11:0] note_col, line_col;
    any_note = 1'b0;
    note_col = 12'h000;
    divider  = 1'b0;
    line_col = 12'hFFF;
    in_span  = h11 >= 11'(LANE_X0) && h11 < 11'(LANE_X0 + NUM_LANES * LANE_W);
    hit_row  = v11 == 11'(HIT_Y) || v11 == 11'(HIT_Y + 1);
    for (int i = 0; i < NUM_LANES; i++) begin
      if (here[i]) begin
        any_note = 1'b1;
        note_col = lane_color(i);
      end
`ifdef HIT_FLASH_EN
      if (flash_on[i] && h11 >= 11'(LANE_X0 + i * LANE_W) && h11 < 11'(LANE_X0 + (i + 1) * LANE_W))
        line_col = 12'h0F0;
`endif
    end
    for (int i = 0; i <= NUM_LANES; i++)
      if (h11 == 11'(LANE_X0 + i * LANE_W)) divider = 1'b1;
    rgb_d = 12'h000;
    if (h11 < 11'(H_ACT) && v11 < 11'(V_ACT)) begin
      if (any_note)               rgb_d = note_col;
      else if (in_span && hit_row) rgb_d = line_col;
      else if (divider)           rgb_d = 12'h444;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb        <= 12'h000;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      rgb        <= rgb_d;
      hit_pulse  <= |hit_now;
      miss_pulse <= |miss_now;
    end
  end
endmodule

// File: tb/tb_note_highway_renderer.sv
// Directed bench for note_highway_renderer: render table plus spawn/hit/miss/reset sequences.
module tb_note_highway_renderer;
  logic clk = 1'b0, rst = 1'b1;
  logic [9:0] h_count = '0, v_count = '0;
  logic note_valid = 1'b0, hit_valid = 1'b0;
  logic [1:0] note_lane = '0, hit_lane = '0;
  logic note_ready, hit_pulse, miss_pulse;
  logic [11:0] rgb;
  int n_vec = 0, n_bad = 0;

  typedef struct { int h; int v; logic [11:0] e; } vec_t;
  vec_t tbl [21];

  note_highway_renderer dut (
    .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
    .note_valid(note_valid), .note_lane(note_lane), .note_ready(note_ready),
    .hit_valid(hit_valid), .hit_lane(hit_lane), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .rgb(rgb)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // called at a negedge; drives the pixel and checks rgb one clock later
  task automatic pix(input int h, input int v, input logic [11:0] e, input string nm);
    h_count = 10'(h);
    v_count = 10'(v);
    @(negedge clk);
    chk(32'(rgb), 32'(e), nm);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      v_count = 10'd480;
      @(negedge clk);
      @(negedge clk);
      v_count = 10'd0;
      @(negedge clk);
    end
  endtask

  task automatic spawn(input logic [1:0] l);
    note_valid = 1'b1;
    note_lane  = l;
    @(negedge clk);
    note_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{200, 10, 12'h0F0}; tbl[1]  = '{200, 25, 12'h0F0}; tbl[2]  = '{200, 26, 12'h000};
    tbl[3]  = '{200,  9, 12'h000}; tbl[4]  = '{164, 12, 12'h0F0}; tbl[5]  = '{163, 12, 12'h000};
    tbl[6]  = '{235, 12, 12'h0F0}; tbl[7]  = '{236, 12, 12'h000}; tbl[8]  = '{160, 12, 12'h444};
    tbl[9]  = '{240, 10, 12'h444}; tbl[10] = '{480,100, 12'h444}; tbl[11] = '{481,100, 12'h000};
    tbl[12] = '{200,440, 12'hFFF}; tbl[13] = '{200,441, 12'hFFF}; tbl[14] = '{200,442, 12'h000};
    tbl[15] = '{159,440, 12'h000}; tbl[16] = '{479,440, 12'hFFF}; tbl[17] = '{640,440, 12'h000};
    tbl[18] = '{700,100, 12'h000}; tbl[19] = '{200,500, 12'h000}; tbl[20] = '{160,440, 12'hFFF};

    @(negedge clk);
    chk(32'(rgb), 0, "reset_rgb");
    chk(32'(hit_pulse), 0, "reset_hit");
    chk(32'(miss_pulse), 0, "reset_miss");
    chk(32'(note_ready), 1, "reset_ready");

    // 1: spawn lane 0 right after reset, 5 ticks -> y=10, then the render table
    rst = 1'b0;
    spawn(2'd0);
    ticks(5);
    for (int i = 0; i < 21; i++) pix(tbl[i].h, tbl[i].v, tbl[i].e, $sformatf("rgb_vec[%0d]", i));

    // 2: fill lane 1
    do_reset();
    note_valid = 1'b1;
    note_lane  = 2'd1;
    repeat (8) @(negedge clk);
    chk(32'(note_ready), 0, "lane1_full");
    note_lane = 2'd2;
    #1 chk(32'(note_ready), 1, "lane2_ready");
    note_lane = 2'd1;
    @(negedge clk);
    note_valid = 1'b0;
    chk(32'(note_ready), 0, "lane1_still_full");
    pix(280, 5, 12'hF00, "lane1_note");

    // 3: hit a lane 2 note at y=432, then repeat the hit
    do_reset();
    spawn(2'd2);
    ticks(216);
    pix(360, 432, 12'hFF0, "lane2_at_432");
    pix(360, 440, 12'hFF0, "note_over_hitline");
    hit_valid = 1'b1;
    hit_lane  = 2'd2;
    @(negedge clk);
    hit_valid = 1'b0;
    chk(32'(hit_pulse), 1, "hit_pulse");
    @(negedge clk);
    chk(32'(hit_pulse), 0, "hit_pulse_one_cycle");
    pix(360, 432, 12'h000, "lane2_freed");
`ifdef HIT_FLASH_EN
    pix(360, 440, 12'h0F0, "hitline_after_hit");
`else
    pix(360, 440, 12'hFFF, "hitline_after_hit");
`endif
    hit_valid = 1'b1;
    @(negedge clk);
    hit_valid = 1'b0;
    chk(32'(hit_pulse), 0, "repeat_hit_no_pulse");

    // 4: lane 3 note at 454 falls past the window
    do_reset();
    spawn(2'd3);
    ticks(227);
    note_lane = 2'd3;
    pix(440, 454, 12'h00F, "lane3_at_454");
    v_count = 10'd480;
    @(negedge clk);
    chk(32'(note_ready), 0, "ready_low_on_tick");
    @(negedge clk);
    chk(32'(miss_pulse), 1, "miss_pulse");
    chk(32'(hit_pulse), 0, "miss_no_hit");
    v_count = 10'd0;
    @(negedge clk);
    chk(32'(miss_pulse), 0, "miss_one_cycle");
    pix(440, 460, 12'h000, "missed_cleared");

    // 5: hit and tick in the same cycle
    do_reset();
    spawn(2'd3);
    ticks(227);
    v_count = 10'd480;
    @(negedge clk);
    hit_valid = 1'b1;
    hit_lane  = 2'd3;
    @(negedge clk);
    hit_valid = 1'b0;
    chk(32'(hit_pulse), 1, "hit_tick_hit");
    chk(32'(miss_pulse), 0, "hit_tick_no_miss");
    v_count = 10'd0;
    @(negedge clk);
    pix(440, 454, 12'h000, "hit_tick_cleared");
    pix(440, 460, 12'h000, "hit_tick_not_advanced");

    // 6: reset mid-frame with five notes active
    do_reset();
    spawn(2'd0); spawn(2'd0); spawn(2'd1); spawn(2'd2); spawn(2'd3);
    ticks(2);
    pix(200, 4, 12'h0F0, "pre_rst_lane0");
    pix(440, 4, 12'h00F, "pre_rst_lane3");
    rst = 1'b1;
    #1;
    chk(32'(rgb), 0, "midrst_rgb");
    chk(32'(hit_pulse), 0, "midrst_hit");
    chk(32'(miss_pulse), 0, "midrst_miss");
    for (int l = 0; l < 4; l++) begin
      note_lane = 2'(l);
      #1 chk(32'(note_ready), 1, $sformatf("midrst_ready[%0d]", l));
    end
    @(negedge clk);
    rst = 1'b0;
    pix(200, 4, 12'h000, "post_rst_lane0");
    pix(700, 100, 12'h000, "post_rst_outside");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
